capdriver_seq: RTL and testbench

CAPDRIVER_SEQ -- requirements
Module: capdriver_seq

---
 rtl/capdriver_seq.sv | 154 +++++++++++++++
 tb/tb_capdriver_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capdriver_seq.sv
`default_nettype none
// ============================================================================
// capdriver_seq : applies a captured capacitor drive word one GROUP at a time,
// MSB group first. Define CAPDRIVER_BBM_EN for break-before-make enables.
// Revision: 1.0
// ============================================================================
module capdriver_seq #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dac_state,
    input  logic             dac_drive_invert,
    input  logic             upd_valid,
    output logic             upd_ready,
    output logic [WIDTH-1:0] dac_drive,
    output logic [WIDTH-1:0] dac_drive_en,
    output logic             upd_done,
    output logic             busy
);
    localparam int NGROUPS = WIDTH / GROUP;
    localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

    generate
        if ((WIDTH % GROUP) != 0) begin : g_bad_group
            $error("capdriver_seq: WIDTH must be an integer multiple of GROUP");
        end
    endgenerate

`ifdef CAPDRIVER_BBM_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2,
        S_BREAK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] drive_q, drive_d;
    logic [GW-1:0]    grp_q, grp_d;
    logic [GROUP-1:0] tgt_grp;
    logic             last_grp;

    assign tgt_grp  = target_q[grp_q*GROUP +: GROUP];
    assign last_grp = (grp_q == '0);

`ifdef CAPDRIVER_BBM_EN
    logic [WIDTH-1:0] en_q, en_d;
    logic [GROUP-1:0] cur_grp;

    assign cur_grp = drive_q[grp_q*GROUP +: GROUP];
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        drive_d  = drive_q;
        grp_d    = grp_q;
`ifdef CAPDRIVER_BBM_EN
        en_d     = en_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (upd_valid) begin
                    target_d = dac_drive_invert ? dac_state : ~dac_state;
                    grp_d    = GW'(NGROUPS - 1);
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
`ifdef CAPDRIVER_BBM_EN
                // Changing groups get their drivers released for one cycle first.
                if (tgt_grp != cur_grp) begin
                    en_d[grp_q*GROUP +: GROUP] = '0;
                    state_d = S_BREAK;
                end else begin
                    drive_d[grp_q*GROUP +: GROUP] = tgt_grp;
                    if (last_grp) begin
                        state_d = S_DONE;
                    end else begin
                        grp_d = grp_q - 1'b1;
                    end
                end
`else
                drive_d[grp_q*GROUP +: GROUP] = tgt_grp;
                if (last_grp) begin
                    state_d = S_DONE;
                end else begin
                    grp_d = grp_q - 1'b1;
                end
`endif
            end
`ifdef CAPDRIVER_BBM_EN
            S_BREAK: begin
                drive_d[grp_q*GROUP +: GROUP] = tgt_grp;
                en_d[grp_q*GROUP +: GROUP]    = '1;
                if (last_grp) begin
                    state_d = S_DONE;
                end else begin
                    grp_d   = grp_q - 1'b1;
                    state_d = S_APPLY;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            drive_q  <= '0;
            grp_q    <= '0;
`ifdef CAPDRIVER_BBM_EN
            en_q     <= '1;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            drive_q  <= drive_d;
            grp_q    <= grp_d;
`ifdef CAPDRIVER_BBM_EN
            en_q     <= en_d;
`endif
        end
    end

    assign dac_drive = drive_q;
`ifdef CAPDRIVER_BBM_EN
    assign dac_drive_en = en_q;
`else
    assign dac_drive_en = '1;
`endif
    assign upd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign upd_done  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_capdriver_seq.sv
`default_nettype none
// ============================================================================
// tb_capdriver_seq : directed and randomized checks of capdriver_seq against a
// per-edge expected-trace model derived from the group update rules.
// Revision: 1.0
// ============================================================================
module tb_capdriver_seq;
    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  dac_state = '0;
    logic          dac_drive_invert = 1'b1;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [W-1:0]  dac_drive;
    logic [W-1:0]  dac_drive_en;
    logic          upd_done;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  model_drv = '0;
    logic [W-1:0]  exp_drv[$];
    logic [W-1:0]  exp_en[$];
    logic [W-1:0]  obs_drv[$];
    logic [W-1:0]  obs_en[$];

    capdriver_seq #(.WIDTH(W), .GROUP(G)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dac_state        (dac_state),
        .dac_drive_invert (dac_drive_invert),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .dac_drive        (dac_drive),
        .dac_drive_en     (dac_drive_en),
        .upd_done         (upd_done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected (drive, enable) after each edge following the handshake.
    task automatic build_expected(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W-1:0] d;
        logic [W-1:0] e;
        exp_drv.delete();
        exp_en.delete();
        d = cur;
        for (int g = NG - 1; g >= 0; g--) begin
`ifdef CAPDRIVER_BBM_EN
            if (d[g*G +: G] != tgt[g*G +: G]) begin
                e = '1;
                e[g*G +: G] = '0;
                exp_drv.push_back(d);
                exp_en.push_back(e);
            end
`endif
            d[g*G +: G] = tgt[g*G +: G];
            exp_drv.push_back(d);
            exp_en.push_back('1);
        end
        e = '0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (upd_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("ready_timeout", {31'd0, upd_ready}, 32'd1);
    endtask

    // Runs from just after the handshake edge through return to IDLE.
    task automatic run_seq(input logic [W-1:0] tgt, input bit midchg, input logic inv);
        obs_drv.delete();
        obs_en.delete();
        chk("hs_busy", {31'd0, busy}, 32'd1);
        chk("hs_ready", {31'd0, upd_ready}, 32'd0);
        chk("hs_drive_hold", {16'd0, dac_drive}, {16'd0, model_drv});
        for (int i = 0; i < exp_drv.size(); i++) begin
            step();
            if (midchg && i == 0) begin
                dac_state        = 16'h1234;
                dac_drive_invert = ~inv;
            end
            obs_drv.push_back(dac_drive);
            obs_en.push_back(dac_drive_en);
            chk("seq_drive", {16'd0, dac_drive}, {16'd0, exp_drv[i]});
            chk("seq_en", {16'd0, dac_drive_en}, {16'd0, exp_en[i]});
            chk("seq_done", {31'd0, upd_done}, (i == exp_drv.size() - 1) ? 32'd1 : 32'd0);
        end
        chk("done_busy", {31'd0, busy}, 32'd1);
        step();
        chk("done_pulse_end", {31'd0, upd_done}, 32'd0);
        chk("idle_ready", {31'd0, upd_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_drive", {16'd0, dac_drive}, {16'd0, tgt});
        model_drv = tgt;
    endtask

    task automatic do_update(input logic [W-1:0] st, input logic inv, input bit midchg);
        logic [W-1:0] tgt;
        wait_ready();
        tgt = inv ? st : ~st;
        build_expected(model_drv, tgt);
        dac_state        = st;
        dac_drive_invert = inv;
        upd_valid        = 1'b1;
        step();
        upd_valid = 1'b0;
        run_seq(tgt, midchg, inv);
    endtask

    initial begin
        logic [W-1:0] st1;
        logic [W-1:0] st2;
        int           cnt;

        // Reset state held while rst_n is low
        repeat (3) step();
        chk("rst_drive", {16'd0, dac_drive}, 32'h0000);
        chk("rst_en", {16'd0, dac_drive_en}, 32'hFFFF);
        chk("rst_ready", {31'd0, upd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, upd_done}, 32'd0);
        rst_n = 1'b1;
        step();

        // Pass-through, MSB group first
        do_update(16'hA5C3, 1'b1, 1'b0);
`ifndef CAPDRIVER_BBM_EN
        chk("order_len", obs_drv.size(), 32'd4);
        if (obs_drv.size() == 4) begin
            chk("order_e1", {16'd0, obs_drv[0]}, 32'hA000);
            chk("order_e2", {16'd0, obs_drv[1]}, 32'hA500);
            chk("order_e3", {16'd0, obs_drv[2]}, 32'hA5C0);
            chk("order_e4", {16'd0, obs_drv[3]}, 32'hA5C3);
        end
`endif

        // Inversion with input change mid-sequence
        do_update(16'h00FF, 1'b0, 1'b1);
        chk("invert_final", {16'd0, dac_drive}, 32'hFF00);

        // Randomized updates
        for (int k = 0; k < 10; k++) begin
            do_update(16'($urandom), 1'($urandom), 1'($urandom));
        end

        // Target equal to current drive still runs a full sequence
        do_update(model_drv, 1'b1, 1'b0);
        chk("same_len", obs_drv.size(), NG);

        // upd_valid held high: one capture per handshake, no queueing
        wait_ready();
        st1 = 16'($urandom);
        st2 = ~st1 ^ 16'h0F0F;
        build_expected(model_drv, st1);
        dac_state = st1;
        dac_drive_invert = 1'b1;
        upd_valid = 1'b1;
        step();
        dac_state = st2;
        cnt = 0;
        while (upd_ready !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk("hold_spacing", cnt + 1, exp_drv.size() + 2);
        chk("hold_first", {16'd0, dac_drive}, {16'd0, st1});
        model_drv = st1;
        build_expected(model_drv, st2);
        step();
        upd_valid = 1'b0;
        run_seq(st2, 1'b0, 1'b1);
        chk("hold_second", {16'd0, dac_drive}, {16'd0, st2});

        // Abort by reset mid-update
        wait_ready();
        dac_state = 16'h7BDE;
        dac_drive_invert = 1'b1;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_drive", {16'd0, dac_drive}, 32'h0000);
        chk("abort_en", {16'd0, dac_drive_en}, 32'hFFFF);
        chk("abort_ready", {31'd0, upd_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        model_drv = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_abort_done", {31'd0, upd_done}, 32'd0);
            chk("post_abort_ready", {31'd0, upd_ready}, 32'd1);
            chk("post_abort_drive", {16'd0, dac_drive}, 32'h0000);
        end

`ifdef CAPDRIVER_BBM_EN
        // Break-before-make on changing groups only
        do_update(16'hF00F, 1'b1, 1'b0);
        chk("bbm_len", obs_drv.size(), 32'd6);
        if (obs_drv.size() == 6) begin
            chk("bbm_en1", {16'd0, obs_en[0]}, 32'h0FFF);
            chk("bbm_drv1", {16'd0, obs_drv[0]}, 32'h0000);
            chk("bbm_drv2", {16'd0, obs_drv[1]}, 32'hF000);
            chk("bbm_en3", {16'd0, obs_en[2]}, 32'hFFFF);
            chk("bbm_en4", {16'd0, obs_en[3]}, 32'hFFFF);
            chk("bbm_en5", {16'd0, obs_en[4]}, 32'hFFF0);
            chk("bbm_drv6", {16'd0, obs_drv[5]}, 32'hF00F);
            chk("bbm_en6", {16'd0, obs_en[5]}, 32'hFFFF);
        end
`else
        do_update(16'hF00F, 1'b1, 1'b0);
        chk("nobbm_len", obs_drv.size(), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
